// File: rtl/fifo_pkg.sv
// Helpers shared by the synchronous FIFO and its read-side stream adapter.
package fifo_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int LEVEL_W(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// stream_skid_buf: small circular buffer with push/pop and an occupancy level.
// The head entry is presented combinationally from registered storage.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int LVL_W     = LEVEL_W(DEPTH)
) (
  input  logic                  clk,
  input  logic                  sclr_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [LVL_W-1:0]      level
);

  logic [DATA_WIDTH-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [LVL_W-1:0]      level_next;
  logic                  do_pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (!sclr_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= din;
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // A pop against an empty buffer is ignored so the level can never underflow.
  assign do_pop = pop && (level_reg != '0);

  always_comb begin
    level_next = level_reg;
    if (push && !do_pop) begin
      level_next = level_reg + 1'b1;
    end else if (do_pop && !push) begin
      level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= PTR_W'(ptr_inc(int'(wr_ptr_reg), DEPTH));
      end
      if (do_pop) begin
        rd_ptr_reg <= PTR_W'(ptr_inc(int'(rd_ptr_reg), DEPTH));
      end
      level_reg <= level_next;
    end
  end

  assign dout  = entry_q[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the FIFO rd_en/empty interface into a valid/ready stream.
// Optional beat counter is enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 2
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                             clk,
  input  logic                             sclr_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  output logic                             fifo_rd_en,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [LEVEL_W(SKID_DEPTH)-1:0]   level
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]             beat_cnt
`endif
);

  localparam int LVL_W = LEVEL_W(SKID_DEPTH);
  localparam int CRD_W = LVL_W + 1;

  logic             inflight_reg;
  logic             pop;
  logic [CRD_W-1:0] credit_used;

  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;

  // Slots already committed (buffered + in flight) once this cycle's pop retires.
  assign credit_used = {1'b0, level} + CRD_W'(inflight_reg) - CRD_W'(pop);
  assign fifo_rd_en  = sclr_n && !fifo_empty && (credit_used < CRD_W'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= fifo_rd_en;
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .sclr_n (sclr_n),
    .push   (inflight_reg),
    .din    (fifo_dout),
    .pop    (pop),
    .dout   (m_data),
    .level  (level)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] beat_cnt_reg;

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      beat_cnt_reg <= '0;
    end else if (pop) begin
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
    end
  end

  assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO model, beat-level reference model
// checked every cycle, plus directed literal checks.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int SD = 2;
  localparam int LW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          sclr_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [LW-1:0] level;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]   beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .SKID_DEPTH (SD)
  ) dut (
    .clk        (clk),
    .sclr_n     (sclr_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  // A word read from the FIFO in cycle c is visible as a beat from cycle c+2.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } ent_t;

  logic [DW-1:0] fq[$];
  ent_t          mq[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int dut_pops = 0;
  int model_cnt = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO model plus reference bookkeeping, evaluated at each rising edge.
  always @(posedge clk) begin
    ent_t e;
    if (!sclr_n) begin
      mq.delete();
      model_cnt = 0;
    end else if (m_ready && mq.size() > 0 && mq[0].cyc + 2 <= cyc) begin
      void'(mq.pop_front());
      model_cnt = (model_cnt + 1) % 65536;
    end
    if (sclr_n && m_valid && m_ready) dut_pops++;
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_dout <= fq[0];
      if (sclr_n) begin
        e.data = fq[0];
        e.cyc  = cyc;
        mq.push_back(e);
      end
      void'(fq.pop_front());
    end
    fifo_empty <= (fq.size() == 0);
    cyc++;
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    int   lvl;
    int   infl;
    logic ev;
    logic epop;
    logic erd;
    logic ok_c;
    if (chk_on) begin
      lvl  = 0;
      infl = 0;
      foreach (mq[i]) begin
        if (mq[i].cyc + 2 <= cyc) lvl++;
        else infl++;
      end
      ev   = (lvl != 0);
      epop = ev && m_ready;
      erd  = sclr_n && !fifo_empty && ((mq.size() - int'(epop)) < SD);
      chk("m_valid", 32'(m_valid), 32'(ev));
      chk("level", 32'(level), 32'(lvl));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(erd));
      if (ev) chk("m_data", 32'(m_data), 32'(mq[0].data));
      ok_c = (int'(level) + infl) <= SD;
      chk("credit", 32'(ok_c), 32'd1);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("beat_cnt", 32'(beat_cnt), 32'(model_cnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int run;
    int base;
    int stale;

    // 1: reset held two cycles with three words waiting in the FIFO
    for (int i = 0; i < 3; i++) fq.push_back(DW'(8'h11 * (i + 1)));
    repeat (2) begin
      @(negedge clk);
      chk("t1_m_valid", 32'(m_valid), 32'd0);
      chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t1_level", 32'(level), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("t1_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    end
    #1 sclr_n = 1'b1;
    m_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t1_pops", 32'(dut_pops), 32'd3);

    // 2: single word latency
    @(posedge clk); #1;
    fq.push_back(8'hA5);
    @(negedge clk); chk("t2_rd_early", 32'(fifo_rd_en), 32'd0);
    @(negedge clk); chk("t2_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk); chk("t2_valid_early", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_data", 32'(m_data), 32'h0000_00A5);
    @(negedge clk);
    chk("t2_level_after", 32'(level), 32'd0);
    chk("t2_valid_after", 32'(m_valid), 32'd0);

    // 3: eight words streamed back to back
    base = dut_pops;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) fq.push_back(DW'(i));
    n = 0;
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    chk("t3_start", 32'(m_valid), 32'd1);
    run = 0;
    while (m_valid && run < 20) begin run++; @(negedge clk); end
    chk("t3_run", 32'(run), 32'd8);
    chk("t3_pops", 32'(dut_pops - base), 32'd8);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("t3_beat_cnt", 32'(beat_cnt), 32'd12);
`endif

    // 4: backpressure fills the buffer, then releases in order
    base = dut_pops;
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fq.push_back(DW'(i));
    repeat (6) @(negedge clk);
    chk("t4_level", 32'(level), 32'd2);
    chk("t4_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t4_valid", 32'(m_valid), 32'd1);
    chk("t4_data", 32'(m_data), 32'd0);
    #1 m_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_pops", 32'(dut_pops - base), 32'd5);

    // 5: random ready with 100 random words
    base = dut_pops;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) fq.push_back(DW'($urandom_range(0, 255)));
    n = 0;
    while ((fq.size() > 0 || mq.size() > 0) && n < 2000) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_pops", 32'(dut_pops - base), 32'd100);

    // 6: reset while one word is buffered and one is in flight
    @(posedge clk); #1;
    m_ready = 1'b0;
    fq.push_back(8'hC1);
    fq.push_back(8'hC2);
    n = 0;
    @(negedge clk);
    while (level != 1 && n < 10) begin @(negedge clk); n++; end
    chk("t6_level_pre", 32'(level), 32'd1);
    #1 sclr_n = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_data", 32'(m_data), 32'd0);
    #1 sclr_n = 1'b1;
    m_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid) stale++;
    end
    chk("t6_stale", 32'(stale), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
